// File: rtl/detect_seq_ctrl.sv
// detect_seq_ctrl: Moore sequencer that arms a detector, holds for cnt_init+1 cycles per detection and counts events.
module detect_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             det,
  input  logic [CNT_W-1:0] cnt_init,
  input  logic             clr_evt,
  output logic             det_ack,
  output logic             cnt_active,
  output logic [CNT_W-1:0] cnt_val,
  output logic             done,
  output logic             busy,
  output logic [EVT_W-1:0] evt_cnt
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] LOAD  = 3'd3;
  localparam logic [2:0] COUNT = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;
  logic [2:0] state, nxt;
  // stop wins over every transition, including start in IDLE
  always_comb begin
    nxt = stop             ? IDLE :
          state == IDLE    ? (start ? ARM : IDLE) :
          state == ARM     ? WAIT :
          state == WAIT    ? (det ? LOAD : WAIT) :
          state == LOAD    ? COUNT :
          state == COUNT   ? (cnt_val == '0 ? ACK : COUNT) :
          state == ACK     ? WAIT : IDLE;
  end
  // datapath updates are suppressed on a stop edge so cnt_val keeps its last value in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt_val <= '0;
      evt_cnt <= '0;
    end else begin
      state <= nxt;
      if (!stop && state == LOAD)
        cnt_val <= cnt_init;
      else if (!stop && state == COUNT && cnt_val != '0)
        cnt_val <= cnt_val - CNT_W'(1);
      if (clr_evt)
        evt_cnt <= '0;
      else if (!stop && state == LOAD && evt_cnt != '1)
        evt_cnt <= evt_cnt + EVT_W'(1);
    end
  end
  assign det_ack    = (state == ARM) || (state == ACK);
  assign cnt_active = state == COUNT;
  assign done       = state == ACK;
  assign busy       = state != IDLE;
endmodule

// File: tb/tb_detect_seq_ctrl.sv
// tb_detect_seq_ctrl: directed per-cycle expectations queued by stimulus, compared by a negedge monitor.
module tb_detect_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, stop, det, clr_evt;
  logic [3:0] cnt_init;
  logic       det_ack, cnt_active, done, busy;
  logic [3:0] cnt_val;
  logic [7:0] evt_cnt;
  logic [15:0] q[$];
  int n_chk = 0;
  int n_fail = 0;

  detect_seq_ctrl #(.CNT_W(4), .EVT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .det(det),
    .cnt_init(cnt_init), .clr_evt(clr_evt), .det_ack(det_ack),
    .cnt_active(cnt_active), .cnt_val(cnt_val), .done(done),
    .busy(busy), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] e(input logic da, ca, dn, bz, input logic [3:0] cv, input logic [7:0] ev);
    return {da, ca, dn, bz, cv, ev};
  endfunction

  function automatic logic [15:0] outs();
    return {det_ack, cnt_active, done, busy, cnt_val, evt_cnt};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ack,act,done,busy,cnt,evt}=%h required %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) chk("cycle", outs(), q.pop_front());

  task automatic cyc(input logic s, p, d, c, input logic [3:0] ci, input logic [15:0] exp);
    start = s; stop = p; det = d; clr_evt = c; cnt_init = ci;
    q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ev, ev1;
    rst = 1'b1; start = 0; stop = 0; det = 0; clr_evt = 0; cnt_init = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 16'h0);
    rst = 1'b0;
    // arm, then a 3-length hold
    cyc(1, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, e(1, 0, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0));
    cyc(0, 0, 1, 0, 3, e(0, 0, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 3, e(0, 0, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 3, e(0, 1, 0, 1, 3, 1));
    cyc(0, 0, 0, 0, 3, e(0, 1, 0, 1, 2, 1));
    cyc(0, 0, 0, 0, 3, e(0, 1, 0, 1, 1, 1));
    cyc(0, 0, 0, 0, 3, e(0, 1, 0, 1, 0, 1));
    cyc(0, 0, 0, 0, 3, e(1, 0, 1, 1, 0, 1));
    cyc(0, 0, 0, 0, 3, e(0, 0, 0, 1, 0, 1));
    // zero-length hold
    cyc(0, 0, 1, 0, 0, e(0, 0, 0, 1, 0, 1));
    cyc(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 1));
    cyc(0, 0, 0, 0, 0, e(0, 1, 0, 1, 0, 2));
    cyc(0, 0, 0, 0, 0, e(1, 0, 1, 1, 0, 2));
    cyc(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 2));
    // det held through LOAD/COUNT is ignored; stop on second COUNT cycle
    cyc(0, 0, 1, 0, 3, e(0, 0, 0, 1, 0, 2));
    cyc(0, 0, 1, 0, 3, e(0, 0, 0, 1, 0, 2));
    cyc(0, 0, 1, 0, 3, e(0, 1, 0, 1, 3, 3));
    cyc(0, 1, 0, 0, 3, e(0, 1, 0, 1, 2, 3));
    cyc(0, 0, 0, 0, 3, e(0, 0, 0, 0, 2, 3));
    cyc(1, 1, 0, 0, 3, e(0, 0, 0, 0, 2, 3));
    cyc(0, 0, 0, 0, 3, e(0, 0, 0, 0, 2, 3));
    // re-arm; clear coincides with LOAD
    cyc(1, 0, 0, 0, 1, e(0, 0, 0, 0, 2, 3));
    cyc(0, 0, 0, 0, 1, e(1, 0, 0, 1, 2, 3));
    cyc(0, 0, 1, 0, 1, e(0, 0, 0, 1, 2, 3));
    cyc(0, 0, 0, 1, 1, e(0, 0, 0, 1, 2, 3));
    cyc(0, 0, 0, 0, 1, e(0, 1, 0, 1, 1, 0));
    cyc(0, 0, 0, 0, 1, e(0, 1, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 1, e(1, 0, 1, 1, 0, 0));
    // 256 detections saturate at 255
    ev = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ev1 = (ev == 8'd255) ? 8'd255 : ev + 8'd1;
      cyc(0, 0, 1, 0, 0, e(0, 0, 0, 1, 0, ev));
      cyc(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, ev));
      cyc(0, 0, 0, 0, 0, e(0, 1, 0, 1, 0, ev1));
      cyc(0, 0, 0, 0, 0, e(1, 0, 1, 1, 0, ev1));
      ev = ev1;
    end
    cyc(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 255));
    // async reset mid-COUNT
    cyc(0, 0, 1, 0, 5, e(0, 0, 0, 1, 0, 255));
    cyc(0, 0, 0, 0, 5, e(0, 0, 0, 1, 0, 255));
    cyc(0, 0, 0, 0, 5, e(0, 1, 0, 1, 5, 255));
    #2;
    chk("pre_async_rst", outs(), e(0, 1, 0, 1, 4, 255));
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 1, 0, 5, e(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 0, 5, e(0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 5, e(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 5, e(1, 0, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 5, e(0, 0, 0, 1, 0, 0));
    @(negedge clk);
    #1;
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/detect_seq_ctrl.md
DETECT_SEQ_CTRL -- requirements
Module: detect_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: width of the hold counter and cnt_init.
REQ-002 Parameter EVT_W, default 8: width of the event counter.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level; leaves IDLE and arms the sequencer.
REQ-006 stop  input  1  level; aborts to IDLE from any state.
REQ-007 det  input  1  detector flag (level, held until acknowledged).
REQ-008 cnt_init  input  CNT_W  hold length, sampled only in LOAD.
REQ-009 clr_evt  input  1  synchronous clear of evt_cnt.
REQ-010 det_ack  output  1  detector release (drives detector en).
REQ-011 cnt_active  output  1  high while the hold counter runs.
REQ-012 cnt_val  output  CNT_W  current hold counter value.
REQ-013 done  output  1  one-cycle pulse at the end of each hold.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 evt_cnt  output  EVT_W  saturating count of accepted detections.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, ARM, WAIT, LOAD, COUNT and ACK; all outputs SHALL decode from state and registers only.
REQ-017 The FSM SHALL move from IDLE to ARM when start=1, and otherwise stay in IDLE.
REQ-018 ARM SHALL last one cycle, assert det_ack=1 to flush any stale detection, then go to WAIT.
REQ-019 The FSM SHALL move from WAIT to LOAD when det=1, and otherwise stay in WAIT.
REQ-020 LOAD SHALL last one cycle: cnt_val <= cnt_init, evt_cnt increments, next state COUNT.
REQ-021 In COUNT, when cnt_val != 0, cnt_val SHALL decrement by 1 per cycle and the FSM stays in COUNT; when cnt_val = 0 the FSM SHALL go to ACK.
REQ-022 COUNT SHALL therefore occupy exactly cnt_init+1 cycles; cnt_init=0 gives one COUNT cycle.
REQ-023 cnt_active SHALL be 1 only in COUNT.
REQ-024 ACK SHALL last one cycle with det_ack=1 and done=1, then go to WAIT (re-armed, no new start needed).
REQ-025 det_ack SHALL be 1 only in ARM and ACK; done SHALL be 1 only in ACK.
REQ-026 stop=1 in any non-IDLE state SHALL force IDLE on the next edge, overriding every other transition; the Moore outputs of the current cycle are unaffected.
REQ-027 start=1 and stop=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-028 det is ignored outside WAIT; a det pulse arriving during COUNT is not queued.
REQ-029 cnt_val SHALL hold its value outside LOAD and COUNT, and SHALL keep its last value on entry to IDLE.
REQ-030 evt_cnt SHALL saturate at 2^EVT_W-1 and never wrap.
REQ-031 clr_evt=1 SHALL zero evt_cnt on the next edge; if it coincides with a LOAD increment, the clear wins (result 0).

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, cnt_val=0, evt_cnt=0, and all of det_ack, cnt_active, done and busy to 0, independent of clk.
REQ-033 rst asserted mid-COUNT SHALL abort the hold with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-034 rst; start=1 for 1 cycle -> ARM (det_ack=1 for one cycle), then WAIT; busy=1 from the cycle after start.
REQ-035 In WAIT, det=1 with cnt_init=3 -> LOAD, COUNT with cnt_val 3,2,1,0 over 4 cycles, ACK with done=det_ack=1 for 1 cycle, evt_cnt=1, back to WAIT.
REQ-036 cnt_init=0 with det=1 -> LOAD, 1 COUNT cycle, ACK; done exactly 1 cycle.
REQ-037 stop=1 on the second COUNT cycle -> IDLE next cycle, no done pulse, busy=0, cnt_val holds.
REQ-038 EVT_W=8, 256 detections -> evt_cnt=255 (no wrap); clr_evt coinciding with LOAD -> evt_cnt=0.
REQ-039 rst pulsed asynchronously mid-COUNT -> all outputs 0 before the next clk edge; start is then required to re-arm.
